// File: rtl/tremolo_pkg.sv
// Shared types and helpers for the multi-channel tremolo.
package tremolo_pkg;

   typedef enum logic {
      WAVE_TRI = 1'b0,
      WAVE_SQR = 1'b1
   } wave_e;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Unity gain code for a gain with gain_w fraction bits.
   function automatic int full_scale(input int gain_w);
      return 1 << gain_w;
   endfunction

endpackage

// File: rtl/tremolo_lfo.sv
// LFO: rate divider, triangle/direction state and the resulting gain.
module tremolo_lfo
   import tremolo_pkg::*;
#(
   parameter int GAIN_W = 8,
   parameter int RATE_W = 20
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [RATE_W-1:0] rate_div,
   input  logic [GAIN_W:0]   depth,
   input  logic              wave_sel,
   output logic [GAIN_W:0]   lfo_gain
);

   localparam int GW1  = GAIN_W + 1;
   localparam int MULW = 2 * GAIN_W + 2;
   localparam logic [GAIN_W:0] FULL = GW1'(full_scale(GAIN_W));

   logic [RATE_W-1:0] div_cnt_q, div_cnt_d;
   logic [GAIN_W:0]   tri_q, tri_d;
   dir_e              dir_q, dir_d;
   logic              tick;

   logic [GAIN_W:0]   depth_sat;
   logic [GAIN_W:0]   wave;
   logic [MULW-1:0]   mod_prod;

   // Next-state for divider and triangle; triangle advances only on a tick.
   always_comb begin
      tick      = (div_cnt_q >= rate_div);
      div_cnt_d = tick ? '0 : div_cnt_q + RATE_W'(1);
      tri_d     = tri_q;
      dir_d     = dir_q;
      if (tick) begin
         if (dir_q == DIR_DOWN) begin
            if (tri_q != '0) begin
               tri_d = tri_q - GW1'(1);
            end else begin
               dir_d = DIR_UP;
               tri_d = GW1'(1);
            end
         end else begin
            if (tri_q != FULL) begin
               tri_d = tri_q + GW1'(1);
            end else begin
               dir_d = DIR_DOWN;
               tri_d = FULL - GW1'(1);
            end
         end
      end
   end

   // LFO state registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt_q <= '0;
         tri_q     <= FULL;
         dir_q     <= DIR_DOWN;
      end else begin
         div_cnt_q <= div_cnt_d;
         tri_q     <= tri_d;
         dir_q     <= dir_d;
      end
   end

   // Gain from registered state: full scale minus depth-scaled dip below unity.
   always_comb begin
      depth_sat = (depth > FULL) ? FULL : depth;
      if (wave_e'(wave_sel) == WAVE_SQR) begin
         wave = (dir_q == DIR_UP) ? FULL : '0;
      end else begin
         wave = tri_q;
      end
      mod_prod = MULW'(depth_sat) * MULW'(FULL - wave);
      lfo_gain = FULL - GW1'(mod_prod >> GAIN_W);
   end

endmodule

// File: rtl/tremolo_mc.sv
// Multi-channel tremolo: 2-stage pipeline applying one LFO gain to every channel of a frame.
module tremolo_mc
   import tremolo_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NUM_CH = 2,
   parameter int GAIN_W = 8,
   parameter int RATE_W = 20
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [RATE_W-1:0]        rate_div,
   input  logic [GAIN_W:0]          depth,
   input  logic                     wave_sel,
   input  logic                     in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     out_valid,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [GAIN_W:0]          lfo_gain
);

   localparam int PROD_W = DATA_W + GAIN_W + 2;

   // Signed sample times unsigned gain, floored back to sample width.
   // The gain never exceeds unity, so the kept bits always hold the full result.
   function automatic logic signed [DATA_W-1:0] scale_floor(
      input logic signed [DATA_W-1:0] s,
      input logic        [GAIN_W:0]   g
   );
      logic signed [PROD_W-1:0] s_x;
      logic signed [PROD_W-1:0] g_x;
      logic signed [PROD_W-1:0] p;
      s_x = PROD_W'(s);
      g_x = $signed({{(PROD_W-GAIN_W-1){1'b0}}, g});
      p   = s_x * g_x;
      return DATA_W'(p >>> GAIN_W);
   endfunction

   logic                     vld_p1_q;
   logic [NUM_CH*DATA_W-1:0] data_p1_q;
   logic [GAIN_W:0]          gain_p1_q;
   logic                     vld_p2_q;
   logic [NUM_CH*DATA_W-1:0] data_p2_q;
   logic [NUM_CH*DATA_W-1:0] data_p2_d;

   tremolo_lfo #(
      .GAIN_W (GAIN_W),
      .RATE_W (RATE_W)
   ) u_lfo (
      .CLK      (CLK),
      .RST      (RST),
      .rate_div (rate_div),
      .depth    (depth),
      .wave_sel (wave_sel),
      .lfo_gain (lfo_gain)
   );

   // Stage 1: capture the frame and the gain in effect before any coincident tick.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_p1_q <= 1'b0;
      end else begin
         vld_p1_q <= in_valid;
      end
      if (in_valid) begin
         data_p1_q <= in_data;
         gain_p1_q <= lfo_gain;
      end
   end

   // Per-channel multipliers feeding stage 2.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign data_p2_d[c*DATA_W +: DATA_W] =
         scale_floor($signed(data_p1_q[c*DATA_W +: DATA_W]), gain_p1_q);
   end

   // Stage 2: register scaled frame; output holds between valid frames.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_p2_q  <= 1'b0;
         data_p2_q <= '0;
      end else begin
         vld_p2_q <= vld_p1_q;
         if (vld_p1_q) begin
            data_p2_q <= data_p2_d;
         end
      end
   end

   assign out_valid = vld_p2_q;
   assign out_data  = data_p2_q;

endmodule

// File: tb/tb_tremolo_mc.sv
// Scoreboard bench for tremolo_mc with directed frames and LFO gain probes.
module tb_tremolo_mc;

   logic        CLK = 1'b0;
   logic        RST;
   logic [19:0] rate_div;
   logic [8:0]  depth;
   logic        wave_sel;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic [8:0]  lfo_gain;

   int checks   = 0;
   int failures = 0;
   logic [31:0] sb_q[$];

   tremolo_mc #(
      .DATA_W (16),
      .NUM_CH (2),
      .GAIN_W (8),
      .RATE_W (20)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .rate_div  (rate_div),
      .depth     (depth),
      .wave_sel  (wave_sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .lfo_gain  (lfo_gain)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic rst_pulse();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   task automatic send(input logic [15:0] c0, input logic [15:0] c1,
                       input logic [15:0] e0, input logic [15:0] e1);
      in_valid = 1'b1;
      in_data  = {c1, c0};
      sb_q.push_back({e1, e0});
      step();
      in_valid = 1'b0;
   endtask

   // Monitor: every presented output frame is matched against the oldest expectation.
   always @(negedge CLK) begin
      if (out_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual=%0h required=no_frame", out_data);
         end else begin
            logic [31:0] exp;
            exp = sb_q.pop_front();
            if (out_data !== exp) begin
               failures++;
               $display("FAIL sb_frame actual=%0h required=%0h", out_data, exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0; rate_div = '0; depth = 9'd0; wave_sel = 1'b0;
      in_valid = 1'b0; in_data = '0;
      step();

      // 1: bypass
      rst_pulse();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_gain", 32'(lfo_gain), 32'd256);
      send(16'h4000, 16'hC000, 16'h4000, 16'hC000);
      chk("bypass_gain_a", 32'(lfo_gain), 32'd256);
      idle(3);
      chk("bypass_gain_b", 32'(lfo_gain), 32'd256);

      // 2: triangle full depth
      depth = 9'd256;
      rst_pulse();
      chk("tri_k0", 32'(lfo_gain), 32'd256);
      step();
      chk("tri_k1", 32'(lfo_gain), 32'd255);
      idle(255);
      chk("tri_k256", 32'(lfo_gain), 32'd0);
      step();
      chk("tri_k257", 32'(lfo_gain), 32'd1);
      idle(255);
      chk("tri_k512", 32'(lfo_gain), 32'd256);
      step();
      chk("tri_k513", 32'(lfo_gain), 32'd255);

      // 3: multiply at gain 128, LFO frozen by a long divider
      rst_pulse();
      idle(128);
      chk("half_gain", 32'(lfo_gain), 32'd128);
      rate_div = 20'd1000;
      send(16'h8000, 16'h7FFF, 16'hC000, 16'h3FFF);
      send(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000);
      send(16'hFF00, 16'h00FF, 16'hFF80, 16'h007F);
      chk("half_gain_hold", 32'(lfo_gain), 32'd128);
      idle(4);

      // 4: square wave, half depth
      wave_sel = 1'b1; depth = 9'd128; rate_div = '0;
      rst_pulse();
      chk("sqr_k0", 32'(lfo_gain), 32'd128);
      send(16'd1000, 16'hFFFD, 16'd500, 16'hFFFE);
      idle(255);
      chk("sqr_k256", 32'(lfo_gain), 32'd128);
      step();
      chk("sqr_k257", 32'(lfo_gain), 32'd256);
      idle(255);
      chk("sqr_k512", 32'(lfo_gain), 32'd256);
      step();
      chk("sqr_k513", 32'(lfo_gain), 32'd128);

      // 5: divider, including lowering rate_div below the count
      wave_sel = 1'b0; depth = 9'd256; rate_div = 20'd9;
      rst_pulse();
      idle(9);
      chk("div_k9", 32'(lfo_gain), 32'd256);
      step();
      chk("div_k10", 32'(lfo_gain), 32'd255);
      idle(9);
      chk("div_k19", 32'(lfo_gain), 32'd255);
      step();
      chk("div_k20", 32'(lfo_gain), 32'd254);
      idle(7);
      chk("div_k27", 32'(lfo_gain), 32'd254);
      rate_div = 20'd3;
      step();
      chk("div_force_tick", 32'(lfo_gain), 32'd253);
      idle(3);
      chk("div_k31", 32'(lfo_gain), 32'd253);
      step();
      chk("div_k32", 32'(lfo_gain), 32'd252);
      idle(4);
      chk("div_k36", 32'(lfo_gain), 32'd251);

      // 6: reset in the middle of a continuous stream
      depth = 9'd0; rate_div = '0;
      idle(2);
      for (int i = 0; i < 6; i++) begin
         send(16'(i * 100), 16'(-i * 100), 16'(i * 100), 16'(-i * 100));
      end
      RST = 1'b1; depth = 9'd256; in_valid = 1'b1; in_data = 32'h1234_5678;
      void'(sb_q.pop_back());
      step();
      RST = 1'b0; in_valid = 1'b0;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", out_data, 32'd0);
      chk("midrst_gain", 32'(lfo_gain), 32'd256);
      for (int j = 0; j < 4; j++) begin
         send(16'h1000, 16'hF000, 16'(16 * (256 - j)), 16'(-16 * (256 - j)));
         if (j == 0) begin
            chk("midrst_valid_hold", 32'(out_valid), 32'd0);
            chk("midrst_data_hold", out_data, 32'd0);
         end
      end
      idle(4);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
